// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: 2-bit saturating-counter BHT indexed by PC,
// EX-stage tracking of the predicted branch, mispredict redirect/flush and a
// saturating mispredict counter.
module branch_predict_ctrl #(
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_id,
  input  logic        is_branch_id,
  input  logic        stall,
  input  logic        resolved_ex,
  input  logic        taken_ex,
  output logic        predict_taken,
  output logic        branch_mux,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [15:0] mispredict_cnt
);

  localparam int IB = $clog2(BHT_ENTRIES);

  logic [1:0]    r_bht [BHT_ENTRIES];
  logic          r_ex_valid;
  logic          r_ex_pred;
  logic [IB-1:0] r_ex_idx;
  logic [15:0]   r_mispredict_cnt;

  logic [IB-1:0] w_idx;
  logic [1:0]    w_bht_rd;
  logic          w_resolve;
  logic          w_mispredict;
  logic [1:0]    w_bht_upd;
  logic          w_unused_pc;

  assign w_idx        = pc_id[IB+1:2];
  assign w_unused_pc  = ^{pc_id[31:IB+2], pc_id[1:0]};
  assign w_bht_rd     = r_bht[w_idx];
  assign w_resolve    = resolved_ex & r_ex_valid;
  assign w_mispredict = w_resolve & (r_ex_pred != taken_ex);

  // Lookup reads the pre-update counter; a redirect in EX kills the ID prediction.
  assign predict_taken  = is_branch_id & w_bht_rd[1] & ~w_mispredict;
  assign branch_mux     = w_mispredict;
  assign flush_if_id    = w_mispredict;
  assign flush_id_ex    = w_mispredict;
  assign mispredict_cnt = r_mispredict_cnt;

  // Saturating next value for the counter of the resolving branch.
  always_comb begin
    w_bht_upd = r_bht[r_ex_idx];
    if (taken_ex) begin
      if (r_bht[r_ex_idx] != 2'b11) w_bht_upd = r_bht[r_ex_idx] + 2'd1;
    end else begin
      if (r_bht[r_ex_idx] != 2'b00) w_bht_upd = r_bht[r_ex_idx] - 2'd1;
    end
  end

  // BHT storage: reset to CNT_INIT, one update per resolved tracked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CNT_INIT;
    end else if (w_resolve) begin
      r_bht[r_ex_idx] <= w_bht_upd;
    end
  end

  // EX tracking register: flush beats stall; a branch resolved while stalled is
  // retired so a held resolve cannot update the table a second time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_pred  <= 1'b0;
      r_ex_idx   <= '0;
    end else if (w_mispredict) begin
      r_ex_valid <= 1'b0;
    end else if (!stall) begin
      r_ex_valid <= is_branch_id;
      r_ex_pred  <= predict_taken;
      r_ex_idx   <= w_idx;
    end else if (w_resolve) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mispredict_cnt <= 16'h0000;
    end else if (w_mispredict && (r_mispredict_cnt != 16'hFFFF)) begin
      r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed testbench for branch_predict_ctrl.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_id;
  logic        is_branch_id;
  logic        stall;
  logic        resolved_ex;
  logic        taken_ex;
  logic        predict_taken;
  logic        branch_mux;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [15:0] mispredict_cnt;

  int n_cmp;
  int n_fail;

  branch_predict_ctrl #(.BHT_ENTRIES(16), .CNT_INIT(2'b01)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_id          (pc_id),
    .is_branch_id   (is_branch_id),
    .stall          (stall),
    .resolved_ex    (resolved_ex),
    .taken_ex       (taken_ex),
    .predict_taken  (predict_taken),
    .branch_mux     (branch_mux),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_id        = 32'h0;
    is_branch_id = 1'b0;
    stall        = 1'b0;
    resolved_ex  = 1'b0;
    taken_ex     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    #1;
    n_cmp++;
    if ({predict_taken, branch_mux, flush_if_id, flush_id_ex} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000",
               {predict_taken, branch_mux, flush_if_id, flush_id_ex});
    end
    n_cmp++;
    if (mispredict_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h want 0000", mispredict_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (dut.r_bht[i] !== 2'b01) begin
        n_fail++;
        $display("FAIL reset_bht[%0d]: got %b want 01", i, dut.r_bht[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_mispredict();
    pc_id = 32'h40; is_branch_id = 1'b1;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pt: got %b want 0", predict_taken);
    end
    tick();
    is_branch_id = 1'b0; resolved_ex = 1'b1; taken_ex = 1'b1;
    #1;
    n_cmp++;
    if ({branch_mux, flush_if_id, flush_id_ex} !== 3'b111) begin
      n_fail++;
      $display("FAIL first_redirect: got %b want 111", {branch_mux, flush_if_id, flush_id_ex});
    end
    tick();
    resolved_ex = 1'b0; taken_ex = 1'b0;
    #1;
    n_cmp++;
    if (mispredict_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL first_cnt: got %0d want 1", mispredict_cnt);
    end
    n_cmp++;
    if (dut.r_bht[0] !== 2'b10) begin
      n_fail++;
      $display("FAIL first_bht0: got %b want 10", dut.r_bht[0]);
    end
    n_cmp++;
    if (branch_mux !== 1'b0) begin
      n_fail++;
      $display("FAIL first_mux_clear: got %b want 0", branch_mux);
    end
  endtask

  task automatic test_train_saturate();
    for (int k = 0; k < 3; k++) begin
      pc_id = 32'h40; is_branch_id = 1'b1;
      #1;
      n_cmp++;
      if (predict_taken !== 1'b1) begin
        n_fail++;
        $display("FAIL train_pt[%0d]: got %b want 1", k, predict_taken);
      end
      tick();
      is_branch_id = 1'b0; resolved_ex = 1'b1; taken_ex = 1'b1;
      #1;
      n_cmp++;
      if ({branch_mux, flush_if_id, flush_id_ex} !== 3'b000) begin
        n_fail++;
        $display("FAIL train_flush[%0d]: got %b want 000", k,
                 {branch_mux, flush_if_id, flush_id_ex});
      end
      tick();
      resolved_ex = 1'b0; taken_ex = 1'b0;
    end
    #1;
    n_cmp++;
    if (dut.r_bht[0] !== 2'b11) begin
      n_fail++;
      $display("FAIL train_bht0_sat: got %b want 11", dut.r_bht[0]);
    end
    n_cmp++;
    if (mispredict_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL train_cnt: got %0d want 1", mispredict_cnt);
    end
  endtask

  task automatic test_flush_over_branch();
    // bht[0]=11: predict taken, then resolve not-taken while a new branch is in ID.
    pc_id = 32'h40; is_branch_id = 1'b1;
    tick();
    resolved_ex = 1'b1; taken_ex = 1'b0;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pt_killed: got %b want 0", predict_taken);
    end
    n_cmp++;
    if (branch_mux !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_mux: got %b want 1", branch_mux);
    end
    tick();
    is_branch_id = 1'b0; resolved_ex = 1'b0;
    #1;
    n_cmp++;
    if (dut.r_ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ex_valid: got %b want 0", dut.r_ex_valid);
    end
    n_cmp++;
    if (dut.r_bht[0] !== 2'b10 || mispredict_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL flush_state: got bht0=%b cnt=%0d want bht0=10 cnt=2",
               dut.r_bht[0], mispredict_cnt);
    end
    // Resolve with nothing tracked: ignored entirely.
    resolved_ex = 1'b1; taken_ex = 1'b1;
    #1;
    n_cmp++;
    if (branch_mux !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_mux: got %b want 0", branch_mux);
    end
    tick();
    resolved_ex = 1'b0; taken_ex = 1'b0;
    #1;
    n_cmp++;
    if (dut.r_bht[0] !== 2'b10 || mispredict_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL ignore_state: got bht0=%b cnt=%0d want bht0=10 cnt=2",
               dut.r_bht[0], mispredict_cnt);
    end
  endtask

  task automatic test_stall();
    pc_id = 32'h48; is_branch_id = 1'b1;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_pt: got %b want 0", predict_taken);
    end
    tick();
    stall = 1'b1; pc_id = 32'h40; is_branch_id = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({dut.r_ex_valid, dut.r_ex_pred, dut.r_ex_idx} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL stall_hold: got v=%b p=%b idx=%0d want v=1 p=0 idx=2",
               dut.r_ex_valid, dut.r_ex_pred, dut.r_ex_idx);
    end
    // Cycle 4: resolve (correct, not taken) while still stalled.
    resolved_ex = 1'b1; taken_ex = 1'b0;
    #1;
    n_cmp++;
    if (branch_mux !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_resolve_mux: got %b want 0", branch_mux);
    end
    tick();
    // Held resolve with the opposite outcome must not act on the retired branch.
    taken_ex = 1'b1;
    #1;
    n_cmp++;
    if (branch_mux !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_second_mux: got %b want 0", branch_mux);
    end
    tick();
    stall = 1'b0; resolved_ex = 1'b0; taken_ex = 1'b0; is_branch_id = 1'b0;
    #1;
    n_cmp++;
    if (dut.r_bht[2] !== 2'b00 || dut.r_bht[0] !== 2'b10 || mispredict_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_single_update: got bht2=%b bht0=%b cnt=%0d want bht2=00 bht0=10 cnt=2",
               dut.r_bht[2], dut.r_bht[0], mispredict_cnt);
    end
    tick();
  endtask

  task automatic test_cnt_saturate();
    logic [1:0] exp_pt;
    exp_pt = 2'b10;   // bht[3]: 01 -> predict 0, then 10 -> predict 1
    dut.r_mispredict_cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      pc_id = 32'h4C; is_branch_id = 1'b1;
      #1;
      n_cmp++;
      if (predict_taken !== exp_pt[k]) begin
        n_fail++;
        $display("FAIL sat_pt[%0d]: got %b want %b", k, predict_taken, exp_pt[k]);
      end
      tick();
      is_branch_id = 1'b0; resolved_ex = 1'b1; taken_ex = ~exp_pt[k];
      #1;
      n_cmp++;
      if (branch_mux !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_mux[%0d]: got %b want 1", k, branch_mux);
      end
      tick();
      resolved_ex = 1'b0; taken_ex = 1'b0;
      #1;
      n_cmp++;
      if (mispredict_cnt !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got %h want FFFF", k, mispredict_cnt);
      end
    end
  endtask

  task automatic test_reset_midflight();
    pc_id = 32'h40; is_branch_id = 1'b1;   // bht[0]=10 -> predict taken
    tick();
    is_branch_id = 1'b0; resolved_ex = 1'b1; taken_ex = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({branch_mux, flush_if_id, flush_id_ex} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_flush: got %b want 000", {branch_mux, flush_if_id, flush_id_ex});
    end
    n_cmp++;
    if (mispredict_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL rstmid_cnt: got %h want 0000", mispredict_cnt);
    end
    tick();
    resolved_ex = 1'b0; taken_ex = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (dut.r_bht[i] !== 2'b01) begin
        n_fail++;
        $display("FAIL rstmid_bht[%0d]: got %b want 01", i, dut.r_bht[i]);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_first_mispredict();
    test_train_saturate();
    test_flush_over_branch();
    test_stall();
    test_cnt_saturate();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
